// File: rtl/fabric_pkg.sv
// Shared types and the standard address map for the data-side bus fabric.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fabric_pkg;

    // One entry per accepted request, recording where its response must come from.
    typedef struct packed {
        logic       unmapped;
        logic [3:0] idx;
    } fifo_entry_t;

    // Standard memory map
    localparam logic [31:0] ADDR_BASE_RAM    = 32'h0000_0000;
    localparam logic [31:0] ADDR_MASK_RAM    = 32'hFFF0_0000;
    localparam logic [31:0] ADDR_BASE_IO     = 32'h8000_0000;
    localparam logic [31:0] ADDR_MASK_IO     = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_BASE_UART0  = 32'h8000_1000;
    localparam logic [31:0] ADDR_MASK_UART0  = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_BASE_TIMER  = 32'h8000_2000;
    localparam logic [31:0] ADDR_MASK_TIMER  = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_BASE_TIMER1 = 32'h8000_3000;
    localparam logic [31:0] ADDR_MASK_TIMER1 = 32'hFFFF_F000;

endpackage

// File: rtl/data_bus_fabric_if.sv
// Bus bundle between the CPU data port, the fabric and the slave channels.
// Latency: n/a (wires only).
// Backpressure: req/gnt on both sides; responses are not back-pressured.
// Modports: master = environment (core drives m_* requests, slaves drive s_* responses);
//           slave  = the fabric itself.
interface data_bus_fabric_if #(
    parameter int NUM_SLV = 6,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic                         m_req;
    logic                         m_gnt;
    logic                         m_we;
    logic [DW/8-1:0]              m_be;
    logic [AW-1:0]                m_addr;
    logic [DW-1:0]                m_wdata;
    logic                         m_rvalid;
    logic [DW-1:0]                m_rdata;
    logic                         m_err;

    logic [NUM_SLV-1:0]           s_req;
    logic [NUM_SLV-1:0]           s_gnt;
    logic [NUM_SLV-1:0]           s_rvalid;
    logic [NUM_SLV-1:0][DW-1:0]   s_rdata;
    logic [NUM_SLV-1:0]           s_err;
    logic                         s_we;
    logic [DW/8-1:0]              s_be;
    logic [AW-1:0]                s_addr;
    logic [DW-1:0]                s_wdata;

    modport master (
        output m_req, m_we, m_be, m_addr, m_wdata,
        output s_gnt, s_rvalid, s_rdata, s_err,
        input  m_gnt, m_rvalid, m_rdata, m_err,
        input  s_req, s_we, s_be, s_addr, s_wdata
    );

    modport slave (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        input  s_gnt, s_rvalid, s_rdata, s_err,
        output m_gnt, m_rvalid, m_rdata, m_err,
        output s_req, s_we, s_be, s_addr, s_wdata
    );
endinterface

// File: rtl/fabric_order_fifo.sv
// Small synchronous FIFO holding the response order of outstanding requests.
// Latency: a pushed entry is visible at head/tail the cycle after the push.
// Backpressure: push is ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: clk, rst (sync, active-high), push/push_dat, pop, head_dat, tail_dat, full, empty, count.
module fabric_order_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [WIDTH-1:0]             tail_dat,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] tail_q;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];
    assign tail_dat = tail_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tail_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
                tail_q <= push_dat;
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/data_bus_fabric.sv
// Data-side interconnect: decodes CPU requests by base/mask onto NUM_SLV slaves, returns responses in order.
// Latency: request and mapped response paths are combinational; unmapped error 1 cycle after grant.
// Backpressure: m_gnt withheld when MAX_OUT outstanding, on a slave switch until drained, or during a timeout abort.
// Ports: clk, rst (sync, active-high), bus (fabric side of data_bus_fabric_if),
//        tmo_flag (sticky timeout indicator), tmo_slv (index of last slave that timed out).
module data_bus_fabric
    import fabric_pkg::*;
#(
    parameter int NUM_SLV = 6,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 1023,
    parameter logic [NUM_SLV-1:0][AW-1:0] SLV_BASE = {32'hFFFF_FFFF, ADDR_BASE_TIMER1, ADDR_BASE_TIMER,
                                                      ADDR_BASE_UART0, ADDR_BASE_IO, ADDR_BASE_RAM},
    parameter logic [NUM_SLV-1:0][AW-1:0] SLV_MASK = {32'hFFFF_FFFF, ADDR_MASK_TIMER1, ADDR_MASK_TIMER,
                                                      ADDR_MASK_UART0, ADDR_MASK_IO, ADDR_MASK_RAM}
) (
    input  logic                clk,
    input  logic                rst,
    data_bus_fabric_if.slave    bus,
    output logic                tmo_flag,
    output logic [3:0]          tmo_slv
);
    localparam int CW  = $clog2(MAX_OUT+1);
    localparam int DCW = $clog2(MAX_OUT+1);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;

    fifo_entry_t                  new_entry;
    fifo_entry_t                  head;
    fifo_entry_t                  tail;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [CW-1:0]                out_cnt;
    logic                         mapped;
    logic [3:0]                   sel;
    logic                         sel_gnt;
    logic                         allowed;
    logic                         gnt;
    logic                         push;
    logic                         pop;
    logic                         head_map;
    logic                         hd_rvalid;
    logic                         hd_err;
    logic [DW-1:0]                hd_rdata;
    logic                         hd_disc;
    logic                         fwd;
    logic                         resp_unm;
    logic                         tmo_abort;
    logic [TW-1:0]                tmo_cnt;
    logic [NUM_SLV-1:0][DCW-1:0]  disc;
    logic [NUM_SLV-1:0]           disc_inc;
    logic [NUM_SLV-1:0]           disc_dec;
    logic [NUM_SLV-1:0]           s_req_c;

    // Address decode: descending scan so the lowest matching index wins.
    always_comb begin
        mapped = 1'b0;
        sel    = '0;
        for (int i = NUM_SLV-1; i >= 0; i--) begin
            if ((bus.m_addr & SLV_MASK[i]) == SLV_BASE[i]) begin
                mapped = 1'b1;
                sel    = 4'(i);
            end
        end
        new_entry.unmapped = !mapped;
        new_entry.idx      = sel;
    end

    // Mux the selected slave's grant and the head slave's response.
    always_comb begin
        sel_gnt   = 1'b0;
        hd_rvalid = 1'b0;
        hd_err    = 1'b0;
        hd_rdata  = '0;
        hd_disc   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel == 4'(i)) begin
                sel_gnt = bus.s_gnt[i];
            end
            if (head.idx == 4'(i)) begin
                hd_rvalid = bus.s_rvalid[i];
                hd_err    = bus.s_err[i];
                hd_rdata  = bus.s_rdata[i];
                hd_disc   = (disc[i] != '0);
            end
        end
    end

    assign head_map = !rst && (out_cnt != '0) && !head.unmapped;
    // A slave still owing a response to an aborted request cannot answer the current head.
    assign fwd      = head_map && hd_rvalid && !hd_disc;
    assign resp_unm = !rst && !fifo_empty && head.unmapped;
    // A genuine response in the deadline cycle beats the abort.
    assign tmo_abort = (TIMEOUT != 0) && head_map && !fwd && (tmo_cnt == TW'(TIMEOUT));
    assign pop       = fwd || resp_unm || tmo_abort;

    // Only one target may be in flight at a time, so responses can never reorder.
    assign allowed = !rst && !fifo_full && (fifo_empty || (tail == new_entry)) && !tmo_abort;
    assign gnt     = bus.m_req && allowed && (mapped ? sel_gnt : 1'b1);
    assign push    = gnt;

    always_comb begin
        s_req_c = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            s_req_c[i] = bus.m_req && allowed && mapped && (sel == 4'(i));
        end
    end

    assign bus.s_req    = s_req_c;
    assign bus.m_gnt    = gnt;
    assign bus.m_rvalid = pop;
    assign bus.m_rdata  = fwd ? hd_rdata : '0;
    assign bus.m_err    = fwd ? hd_err : (resp_unm || tmo_abort);
    assign bus.s_we     = bus.m_we;
    assign bus.s_be     = bus.m_be;
    assign bus.s_addr   = bus.m_addr;
    assign bus.s_wdata  = bus.m_wdata;

    fabric_order_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (new_entry),
        .pop      (pop),
        .head_dat (head),
        .tail_dat (tail),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (out_cnt)
    );

    // Pushing into an empty FIFO starts the count so the deadline lands TIMEOUT cycles after grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (pop) begin
            tmo_cnt <= '0;
        end else if (head_map || (fifo_empty && push)) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        disc_inc = '0;
        disc_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            disc_inc[i] = tmo_abort && (head.idx == 4'(i));
            disc_dec[i] = bus.s_rvalid[i] && (disc[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disc     <= '0;
            tmo_flag <= 1'b0;
            tmo_slv  <= '0;
        end else begin
            for (int i = 0; i < NUM_SLV; i++) begin
                disc[i] <= disc[i] + DCW'(disc_inc[i]) - DCW'(disc_dec[i]);
            end
            if (tmo_abort) begin
                tmo_flag <= 1'b1;
                tmo_slv  <= head.idx;
            end
        end
    end
endmodule

// File: tb/tb_data_bus_fabric.sv
// Directed bench for data_bus_fabric: pipelining, slave switch, unmapped, timeout, reset.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 3 units after posedge.
// Backpressure: slaves always grant; responses driven explicitly per cycle.
module tb_data_bus_fabric;
    logic       clk;
    logic       rst;
    logic       tmo_flag;
    logic [3:0] tmo_slv;
    int         n_chk  = 0;
    int         n_fail = 0;

    data_bus_fabric_if #(.NUM_SLV(4), .AW(32), .DW(32)) bus ();

    data_bus_fabric #(
        .NUM_SLV  (4),
        .AW       (32),
        .DW       (32),
        .MAX_OUT  (2),
        .TIMEOUT  (8),
        .SLV_BASE ({32'h0000_2000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000})
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .tmo_flag (tmo_flag),
        .tmo_slv  (tmo_slv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m_req    = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_be     = 4'hF;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.s_gnt    = '1;
        bus.s_rvalid = '0;
        bus.s_err    = '0;
        bus.s_rdata  = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.m_req  = 1'b1;
        bus.m_we   = 1'b0;
        bus.m_addr = a;
    endtask

    task automatic rsp(input int i, input logic [31:0] d, input logic e);
        bus.s_rvalid[i] = 1'b1;
        bus.s_rdata[i]  = d;
        bus.s_err[i]    = e;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        next(); next(); #2;
        chk("rst_gnt",    32'(bus.m_gnt),    0);
        chk("rst_rvalid", 32'(bus.m_rvalid), 0);
        chk("rst_err",    32'(bus.m_err),    0);
        chk("rst_rdata",  bus.m_rdata,       0);
        chk("rst_sreq",   32'(bus.s_req),    0);
        chk("rst_flag",   32'(tmo_flag),     0);
        chk("rst_slv",    32'(tmo_slv),      0);

        // Four back-to-back reads to a zero-wait slave 0
        next(); rst = 1'b0; idle(); rd(32'h0); #2;
        chk("p0_sreq", 32'(bus.s_req), 32'h1);
        chk("p0_gnt", 32'(bus.m_gnt), 1);
        chk("p0_rvalid", 32'(bus.m_rvalid), 0);
        next(); idle(); rd(32'h4); rsp(0, 32'h0, 1'b0); #2;
        chk("p1_gnt", 32'(bus.m_gnt), 1);
        chk("p1_rvalid", 32'(bus.m_rvalid), 1);
        chk("p1_rdata", bus.m_rdata, 32'h0);
        next(); idle(); rd(32'h8); rsp(0, 32'h4, 1'b0); #2;
        chk("p2_gnt", 32'(bus.m_gnt), 1);
        chk("p2_rdata", bus.m_rdata, 32'h4);
        next(); idle(); rd(32'hC); rsp(0, 32'h8, 1'b0); #2;
        chk("p3_gnt", 32'(bus.m_gnt), 1);
        chk("p3_rdata", bus.m_rdata, 32'h8);
        next(); idle(); rsp(0, 32'hC, 1'b0); #2;
        chk("p4_rvalid", 32'(bus.m_rvalid), 1);
        chk("p4_rdata", bus.m_rdata, 32'hC);
        chk("p4_err", 32'(bus.m_err), 0);
        next(); idle(); #2;
        chk("p5_rvalid", 32'(bus.m_rvalid), 0);

        // Slave switch: slave 0 with 3-cycle latency, then slave 2 (overlaps slave 3, lower wins)
        next(); idle(); rd(32'h10); #2;
        chk("sw0_sreq", 32'(bus.s_req), 32'h1);
        chk("sw0_gnt", 32'(bus.m_gnt), 1);
        next(); idle(); rd(32'h2000); #2;
        chk("sw1_sreq", 32'(bus.s_req), 0);
        chk("sw1_gnt", 32'(bus.m_gnt), 0);
        next(); idle(); rd(32'h2000); #2;
        chk("sw2_sreq", 32'(bus.s_req), 0);
        next(); idle(); rd(32'h2000); rsp(0, 32'h55, 1'b0); #2;
        chk("sw3_rvalid", 32'(bus.m_rvalid), 1);
        chk("sw3_rdata", bus.m_rdata, 32'h55);
        chk("sw3_sreq", 32'(bus.s_req), 0);
        chk("sw3_gnt", 32'(bus.m_gnt), 0);
        next(); idle(); rd(32'h2000); #2;
        chk("sw4_sreq", 32'(bus.s_req), 32'h4);
        chk("sw4_gnt", 32'(bus.m_gnt), 1);
        chk("sw4_rvalid", 32'(bus.m_rvalid), 0);
        next(); idle(); rsp(2, 32'h22, 1'b1); #2;
        chk("sw5_rvalid", 32'(bus.m_rvalid), 1);
        chk("sw5_rdata", bus.m_rdata, 32'h22);
        chk("sw5_err", 32'(bus.m_err), 1);

        // Unmapped write; a stray slave-0 response must not leak through
        next(); idle();
        bus.m_req = 1'b1; bus.m_we = 1'b1; bus.m_addr = 32'hDEAD_0000;
        bus.m_wdata = 32'h1234_5678; bus.m_be = 4'h3; #2;
        chk("um0_gnt", 32'(bus.m_gnt), 1);
        chk("um0_sreq", 32'(bus.s_req), 0);
        chk("um0_rvalid", 32'(bus.m_rvalid), 0);
        chk("um0_s_we", 32'(bus.s_we), 1);
        chk("um0_s_addr", bus.s_addr, 32'hDEAD_0000);
        chk("um0_s_be", 32'(bus.s_be), 32'h3);
        next(); idle(); rsp(0, 32'hFFFF, 1'b0); #2;
        chk("um1_rvalid", 32'(bus.m_rvalid), 1);
        chk("um1_err", 32'(bus.m_err), 1);
        chk("um1_rdata", bus.m_rdata, 32'h0);
        next(); idle(); #2;
        chk("um2_rvalid", 32'(bus.m_rvalid), 0);

        // Timeout on slave 3
        next(); idle(); rd(32'h3000); #2;
        chk("to0_sreq", 32'(bus.s_req), 32'h8);
        chk("to0_gnt", 32'(bus.m_gnt), 1);
        for (int k = 1; k < 8; k++) begin
            next(); idle(); #2;
            chk("to_wait_rvalid", 32'(bus.m_rvalid), 0);
        end
        chk("to7_flag", 32'(tmo_flag), 0);
        next(); idle(); rd(32'h3000); #2;
        chk("to8_rvalid", 32'(bus.m_rvalid), 1);
        chk("to8_err", 32'(bus.m_err), 1);
        chk("to8_rdata", bus.m_rdata, 32'h0);
        chk("to8_gnt", 32'(bus.m_gnt), 0);
        chk("to8_sreq", 32'(bus.s_req), 0);
        next(); idle(); #2;
        chk("to9_flag", 32'(tmo_flag), 1);
        chk("to9_slv", 32'(tmo_slv), 3);
        chk("to9_rvalid", 32'(bus.m_rvalid), 0);
        next(); idle(); rd(32'h3004); #2;
        chk("to10_gnt", 32'(bus.m_gnt), 1);
        chk("to10_sreq", 32'(bus.s_req), 32'h8);
        next(); idle(); rsp(3, 32'hBAD, 1'b0); #2;
        chk("to11_late_rvalid", 32'(bus.m_rvalid), 0);
        next(); idle(); rsp(3, 32'h600D, 1'b0); #2;
        chk("to12_rvalid", 32'(bus.m_rvalid), 1);
        chk("to12_rdata", bus.m_rdata, 32'h600D);
        chk("to12_err", 32'(bus.m_err), 0);
        next(); idle(); #2;
        chk("to13_flag", 32'(tmo_flag), 1);

        // Reset with two requests outstanding
        next(); idle(); rd(32'h40); #2;
        chk("rm0_gnt", 32'(bus.m_gnt), 1);
        next(); idle(); rd(32'h44); #2;
        chk("rm1_gnt", 32'(bus.m_gnt), 1);
        next(); idle(); rd(32'h48); #2;
        chk("rm2_full_gnt", 32'(bus.m_gnt), 0);
        chk("rm2_full_sreq", 32'(bus.s_req), 0);
        next(); idle(); rst = 1'b1; #2;
        next(); idle(); rst = 1'b0; #2;
        chk("rm4_count", 32'(dut.out_cnt), 0);
        chk("rm4_rvalid", 32'(bus.m_rvalid), 0);
        chk("rm4_flag", 32'(tmo_flag), 0);
        chk("rm4_slv", 32'(tmo_slv), 0);
        next(); idle(); rd(32'h50); #2;
        chk("rm5_gnt", 32'(bus.m_gnt), 1);
        next(); idle(); rd(32'h54); rsp(0, 32'h50, 1'b0); #2;
        chk("rm6_gnt", 32'(bus.m_gnt), 1);
        chk("rm6_rvalid", 32'(bus.m_rvalid), 1);
        chk("rm6_rdata", bus.m_rdata, 32'h50);
        next(); idle(); rsp(0, 32'h54, 1'b0); #2;
        chk("rm7_rdata", bus.m_rdata, 32'h54);

        // Slave 1 answers exactly in the deadline cycle
        next(); idle(); rd(32'h1000); #2;
        chk("co0_gnt", 32'(bus.m_gnt), 1);
        chk("co0_sreq", 32'(bus.s_req), 32'h2);
        for (int k = 1; k < 8; k++) begin
            next(); idle(); #2;
            chk("co_wait_rvalid", 32'(bus.m_rvalid), 0);
        end
        next(); idle(); rsp(1, 32'h11, 1'b1); #2;
        chk("co8_rvalid", 32'(bus.m_rvalid), 1);
        chk("co8_rdata", bus.m_rdata, 32'h11);
        chk("co8_err", 32'(bus.m_err), 1);
        next(); idle(); #2;
        chk("co9_flag", 32'(tmo_flag), 0);
        chk("co9_rvalid", 32'(bus.m_rvalid), 0);
        next(); idle(); rd(32'h1004); #2;
        chk("co10_gnt", 32'(bus.m_gnt), 1);
        next(); idle(); rsp(1, 32'h77, 1'b0); #2;
        chk("co11_rvalid", 32'(bus.m_rvalid), 1);
        chk("co11_rdata", bus.m_rdata, 32'h77);
        chk("co11_err", 32'(bus.m_err), 0);
        next(); idle(); #2;
        chk("co12_flag", 32'(tmo_flag), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
